// File: rtl/vga_pkg.sv
// Shared VGA raster timing constants and the coordinate type.
// The defaults describe 640x480@60 with a 25 MHz pixel rate.
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int CNT_W = $clog2((DEF_H_TOTAL > DEF_V_TOTAL) ? DEF_H_TOTAL : DEF_V_TOTAL);

    typedef logic [CNT_W-1:0] coord_t;

endpackage

// File: rtl/sync_axis_cnt.sv
// One raster axis: modulo counter plus active/sync window decode.
// Decodes are taken from the next count so registered outputs line up with it.
module sync_axis_cnt
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic   sys_clk,
    input  logic   sys_rst_n,
    input  logic   en,
    output coord_t cnt_nxt,
    output logic   wrap,
    output logic   active_nxt,
    output logic   sync_nxt
);

    localparam int     TOTAL   = ACTIVE + FP + SYNC + BP;
    localparam coord_t LAST    = coord_t'(TOTAL - 1);
    localparam coord_t ACT_END = coord_t'(ACTIVE);
    localparam coord_t SYNC_LO = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_HI = coord_t'(ACTIVE + FP + SYNC);

    coord_t cnt;

    always_comb begin
        wrap    = en && (cnt == LAST);
        cnt_nxt = cnt;
        if (en) begin
            cnt_nxt = (cnt == LAST) ? '0 : cnt + coord_t'(1);
        end
        active_nxt = (cnt_nxt < ACT_END);
        sync_nxt   = (cnt_nxt >= SYNC_LO) && (cnt_nxt < SYNC_HI);
    end

    // Reset to the last blanking position so the first enable lands on 0.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= LAST;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator driven by a pixel enable on the system clock.
// All outputs are registered from the next counter values, so no pixel latency.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pix_ce,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2 ** CNT_W || V_TOTAL > 2 ** CNT_W) begin : g_bad_total
        $error("vga_sync_gen: raster total exceeds counter range");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_width
        $error("vga_sync_gen: every width and porch must be at least 1");
    end

    coord_t h_nxt, v_nxt;
    logic   h_wrap, v_wrap;
    logic   h_act_nxt, v_act_nxt;
    logic   h_sync_nxt, v_sync_nxt;
    logic   v_en;

    assign v_en = pix_ce & h_wrap;

    sync_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_cnt (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .en         (pix_ce),
        .cnt_nxt    (h_nxt),
        .wrap       (h_wrap),
        .active_nxt (h_act_nxt),
        .sync_nxt   (h_sync_nxt)
    );

    sync_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_cnt (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .en         (v_en),
        .cnt_nxt    (v_nxt),
        .wrap       (v_wrap),
        .active_nxt (v_act_nxt),
        .sync_nxt   (v_sync_nxt)
    );

    // h_wrap/v_wrap already include pix_ce, so strobes drop to 0 on idle cycles.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de          <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            if (pix_ce) begin
                de    <= h_act_nxt && v_act_nxt;
                hsync <= h_sync_nxt ? SYNC_POL : ~SYNC_POL;
                vsync <= v_sync_nxt ? SYNC_POL : ~SYNC_POL;
                pix_x <= (h_act_nxt && v_act_nxt) ? h_nxt : '0;
                pix_y <= v_act_nxt ? v_nxt : '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Checks three instances (640x480 active-low, 640x480 active-high, tiny raster)
// against a coordinate-based reference model under directed and random pix_ce.
module tb_vga_sync_gen;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic pix_ce    = 1'b0;

    always #5 sys_clk = ~sys_clk;

    logic       hs [3];
    logic       vs [3];
    logic       de [3];
    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       ls [3];
    logic       fs [3];

    // Per-instance timing: H active/fp/sync/bp, V active/fp/sync/bp, polarity
    int ha [3] = '{640, 640, 8};
    int hf [3] = '{16, 16, 2};
    int hw [3] = '{96, 96, 3};
    int hb [3] = '{48, 48, 2};
    int va [3] = '{480, 480, 4};
    int vf [3] = '{10, 10, 1};
    int vw [3] = '{2, 2, 2};
    int vb [3] = '{33, 33, 2};
    int pol[3] = '{0, 1, 0};

    int mh [3];
    int mv [3];
    int mls[3];
    int mfs[3];

    int n_assert = 0;
    int n_fail   = 0;

    vga_sync_gen u_def (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_ce(pix_ce),
        .hsync(hs[0]), .vsync(vs[0]), .de(de[0]), .pix_x(px[0]), .pix_y(py[0]),
        .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(.SYNC_POL(1'b1)) u_pol1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_ce(pix_ce),
        .hsync(hs[1]), .vsync(vs[1]), .de(de[1]), .pix_x(px[1]), .pix_y(py[1]),
        .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b0)
    ) u_small (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pix_ce(pix_ce),
        .hsync(hs[2]), .vsync(vs[2]), .de(de[2]), .pix_x(px[2]), .pix_y(py[2]),
        .line_start(ls[2]), .frame_start(fs[2])
    );

    function automatic int htot(int k);
        return ha[k] + hf[k] + hw[k] + hb[k];
    endfunction

    function automatic int vtot(int k);
        return va[k] + vf[k] + vw[k] + vb[k];
    endfunction

    task automatic chk(input string tag, input int k, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] at t=%0t (h=%0d v=%0d): observed %0d expected %0d",
                   tag, k, $time, mh[k], mv[k], obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mh[k]  = htot(k) - 1;
            mv[k]  = vtot(k) - 1;
            mls[k] = 0;
            mfs[k] = 0;
        end
    endtask

    task automatic model_advance(input logic ce);
        for (int k = 0; k < 3; k++) begin
            mls[k] = 0;
            mfs[k] = 0;
            if (ce) begin
                mh[k] = (mh[k] + 1) % htot(k);
                if (mh[k] == 0) begin
                    mv[k]  = (mv[k] + 1) % vtot(k);
                    mls[k] = 1;
                    mfs[k] = (mv[k] == 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_all();
        int e_de, e_hs, e_vs, e_px, e_py;
        for (int k = 0; k < 3; k++) begin
            e_de = (mh[k] < ha[k] && mv[k] < va[k]) ? 1 : 0;
            e_hs = (mh[k] >= ha[k] + hf[k] && mh[k] < ha[k] + hf[k] + hw[k]) ? pol[k] : 1 - pol[k];
            e_vs = (mv[k] >= va[k] + vf[k] && mv[k] < va[k] + vf[k] + vw[k]) ? pol[k] : 1 - pol[k];
            e_px = e_de ? mh[k] : 0;
            e_py = (mv[k] < va[k]) ? mv[k] : 0;
            chk("de",          k, int'(de[k]), e_de);
            chk("hsync",       k, int'(hs[k]), e_hs);
            chk("vsync",       k, int'(vs[k]), e_vs);
            chk("pix_x",       k, int'(px[k]), e_px);
            chk("pix_y",       k, int'(py[k]), e_py);
            chk("line_start",  k, int'(ls[k]), mls[k]);
            chk("frame_start", k, int'(fs[k]), mfs[k]);
        end
    endtask

    task automatic step(input logic ce);
        @(negedge sys_clk);
        pix_ce = ce;
        @(posedge sys_clk);
        model_advance(ce);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        sys_rst_n = 1'b0;
        pix_ce    = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_all();

        // Release and free-run: first enable lands on (0,0) with both strobes
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 2500; i++) step(1'b1);

        // Enable every 4th cycle, as from the divider
        for (int i = 0; i < 3400; i++) step((i % 4) == 3);

        // Random enable pattern including idle runs
        for (int i = 0; i < 4000; i++) step($urandom_range(0, 3) == 0);

        // Asynchronous reset mid-line: outputs must drop within the same cycle
        @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        step(1'b0);
        step(1'b1);
        for (int i = 0; i < 1500; i++) step($urandom_range(0, 1) == 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
